// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
//   Registered bitwise gate with valid/ready output stage. Single mode returns
//   a op b one cycle after the beat is accepted. Chain mode folds ACC_LEN
//   accepted beats into one result: the first beat computes a op b, and each
//   later beat combines the running accumulator with b using the op latched
//   on the first beat.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat offered
//   in_ready   beat can be accepted this cycle (output register free or freeing)
//   a, b       WIDTH-bit operands (a ignored on chain beats after the first)
//   op         000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//              110 NOT a, 111 BUF a
//   chain_en   1 = chain mode; sampled on a chain's first beat only
//   out_valid  out_y holds a result
//   out_ready  consumer accepts the result
//   out_y      WIDTH-bit result
//   busy       chain in progress
//
// state | meaning
// IDLE  | no chain open; next accepted beat is single or starts a chain
// ACCUM | chain open; acc holds the partial result, cnt counts accepted beats
module logic_gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int ACC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             chain_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);

    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          CHAIN_OK = (ACC_LEN > 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op_l;

    logic             accept;
    logic             start_chain;
    logic             final_beat;
    logic             load_out;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] next_val;
    logic [2:0]       op_sel;

    function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [2:0]       sel);
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    assign busy     = (state == ACCUM);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Inside a chain the accumulator replaces a and the latched op replaces op.
    assign lhs      = busy ? acc  : a;
    assign op_sel   = busy ? op_l : op;
    assign next_val = gate(lhs, b, op_sel);

    assign start_chain = accept && !busy && chain_en && CHAIN_OK;
    assign final_beat  = busy && (cnt == CNT_LAST);
    assign load_out    = accept && (busy ? final_beat : !start_chain);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            op_l      <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
        end else begin
            // A load in the same cycle as a consume keeps out_valid high.
            if (load_out) begin
                out_y     <= next_val;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (start_chain) begin
                acc   <= next_val;
                op_l  <= op;
                cnt   <= CNT_ONE;
                state <= ACCUM;
            end else if (accept && busy) begin
                if (final_beat) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    acc <= next_val;
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       chain_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .ACC_LEN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .chain_en (chain_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .busy     (busy)
    );

    // Scoreboard: every delivered result is popped and compared in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got out_y=%h with no result expected", out_y);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_y !== e) begin
                    errors++;
                    $display("FAIL sb_value: got out_y=%h expected %h", out_y, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic beat(input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] opv, input logic ce);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op       = opv;
        chain_en = ce;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        beat(8'hF0, 8'hCC, 3'b001, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b y=%h busy=%b rdy=%b expected v=0 y=00 busy=0 rdy=1",
                     out_valid, out_y, busy, in_ready);
        end
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_nothing_accepted: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_truth_sweep();
        logic [7:0] tbl[8];
        tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            beat(8'hF0, 8'hCC, 3'(i), 1'b0);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_y !== tbl[i-1]) begin
                    errors++;
                    $display("FAIL sweep_op%0d: got v=%b y=%h expected v=1 y=%h",
                             i - 1, out_valid, out_y, tbl[i-1]);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_y !== tbl[7]) begin
            errors++;
            $display("FAIL sweep_op7: got v=%b y=%h expected v=1 y=%h", out_valid, out_y, tbl[7]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(8'hF0, 8'hCC, 3'b001, 1'b0);
        exp_q.push_back(8'hFC);
        @(posedge clk); #1;
        beat(8'hF0, 8'hCC, 3'b010, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_y !== 8'hFC || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b y=%h rdy=%b expected v=1 y=fc rdy=0",
                         k, out_valid, out_y, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_y !== 8'hFC) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b y=%h expected rdy=1 y=fc", in_ready, out_y);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h3C) begin
            errors++;
            $display("FAIL bp_next: got v=%b y=%h expected v=1 y=3c", out_valid, out_y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_chain_xor();
        logic [7:0] bs[4];
        bs = '{8'h02, 8'h03, 8'h04, 8'h08};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            // op switches to AND and chain_en drops mid-chain; both must be ignored.
            beat((i == 0) ? 8'h01 : 8'hFF, bs[i], (i >= 2) ? 3'b000 : 3'b010, (i == 0));
            if (i == 3) exp_q.push_back(8'h0C);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL chain_mid_beat%0d: got busy=%b v=%b expected busy=1 v=0",
                             i, busy, out_valid);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h0C) begin
            errors++;
            $display("FAIL chain_result: got busy=%b v=%b y=%h expected busy=0 v=1 y=0c",
                     busy, out_valid, out_y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_chain();
        logic [7:0] bs[4];
        bs = '{8'h0F, 8'h3C, 8'hF4, 8'hFF};
        out_ready = 1'b1;
        @(posedge clk); #1;
        beat(8'h11, 8'h22, 3'b001, 1'b1);
        @(posedge clk); #1;
        beat(8'h00, 8'h44, 3'b001, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_chain: got busy=%b v=%b expected 0 0", busy, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            beat((i == 0) ? 8'hFF : 8'h00, bs[i], 3'b000, (i == 0));
            if (i == 3) exp_q.push_back(8'h04);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h04 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_new_chain: got v=%b y=%h busy=%b expected v=1 y=04 busy=0",
                     out_valid, out_y, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps_stall();
        logic [7:0] bs[3];
        bs = '{8'hFF, 8'h3C, 8'hC3};
        out_ready = 1'b0;
        @(posedge clk); #1;
        beat(8'hF0, 8'h3C, 3'b000, 1'b0);
        exp_q.push_back(8'h30);
        @(posedge clk); #1;
        beat(8'hA5, 8'h0F, 3'b010, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h30 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_first: got v=%b y=%h rdy=%b busy=%b expected v=1 y=30 rdy=0 busy=0",
                     out_valid, out_y, in_ready, busy);
        end
        out_ready = 1'b1;
        exp_q.push_back(8'hAA);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold%0d: got busy=%b v=%b expected busy=1 v=0",
                         i, busy, out_valid);
            end
            @(posedge clk); #1;
            beat(8'h00, bs[i], 3'b001, 1'b0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        // Final beat has been accepted; offer a single beat that must stall.
        beat(8'h01, 8'h02, 3'b001, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_y !== 8'hAA || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stall_final%0d: got v=%b y=%h rdy=%b busy=%b expected v=1 y=aa rdy=0 busy=0",
                         k, out_valid, out_y, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        exp_q.push_back(8'h03);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'h03) begin
            errors++;
            $display("FAIL stall_after: got v=%b y=%h expected v=1 y=03", out_valid, out_y);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        chain_en  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_truth_sweep();
        test_backpressure();
        test_chain_xor();
        test_reset_mid_chain();
        test_gaps_stall();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d undelivered results expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
